// File: rtl/tinyalu_driver.sv
// Command initiator for the tinyalu start/done interface: one command in flight,
// valid/ready on both sides. Optional performance counters under TINYALU_DRV_PERF_EN.
module tinyalu_driver #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef TINYALU_DRV_PERF_EN
    output logic [CNT_W-1:0] perf_cmd_cnt,
    output logic [CNT_W-1:0] perf_err_cnt,
    output logic [CNT_W-1:0] perf_busy_cnt,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_A,
    output logic [7:0]       alu_B,
    input  logic             alu_done,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [2:0]       rsp_op,
    output logic             rsp_err
);

    // Handshakes: a transfer happens on any rising clk edge where valid and ready
    // are both high; a source holds valid and its payload stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        alu_start_q, alu_start_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [2:0]  rsp_op_q, rsp_op_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cmd_is_alu;

    assign cmd_is_alu = (cmd_op >= 3'd1) && (cmd_op <= 3'd4);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = cmd_ready_q;
        alu_start_d  = alu_start_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                // cmd_ready is registered so it is low during reset and rises one cycle after.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    rsp_op_d    = cmd_op;
                    cnt_d       = 8'd0;
                    if (cmd_is_alu) begin
                        state_d     = S_ISSUE;
                        alu_start_d = 1'b1;
                        alu_op_d    = cmd_op;
                        alu_a_d     = cmd_a;
                        alu_b_d     = cmd_b;
                    end else begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = 16'h0000;
                        rsp_err_d    = (cmd_op != 3'd0);
                    end
                end
            end
            S_ISSUE: begin
                // A done landing on the terminal count still counts as a normal completion.
                if (alu_done) begin
                    state_d      = S_RESP;
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    cnt_d        = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_RESP;
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = 16'h0000;
                    rsp_err_d    = 1'b1;
                    cnt_d        = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            cmd_ready_q  <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_op_q     <= 3'd0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'h0000;
            rsp_op_q     <= 3'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            alu_start_q  <= alu_start_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_op_q;
    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_err    = rsp_err_q;

`ifdef TINYALU_DRV_PERF_EN
    logic [CNT_W-1:0] perf_cmd_q, perf_cmd_d;
    logic [CNT_W-1:0] perf_err_q, perf_err_d;
    logic [CNT_W-1:0] perf_busy_q, perf_busy_d;
    logic             rsp_fire;

    assign rsp_fire = rsp_valid_q && rsp_ready;

    // All counters stick at all-ones instead of wrapping.
    always_comb begin
        perf_cmd_d  = perf_cmd_q;
        perf_err_d  = perf_err_q;
        perf_busy_d = perf_busy_q;
        if (rsp_fire && (perf_cmd_q != '1)) begin
            perf_cmd_d = perf_cmd_q + CNT_W'(1);
        end
        if (rsp_fire && rsp_err_q && (perf_err_q != '1)) begin
            perf_err_d = perf_err_q + CNT_W'(1);
        end
        if ((state_q == S_ISSUE) && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cmd_q  <= '0;
            perf_err_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_cmd_q  <= perf_cmd_d;
            perf_err_q  <= perf_err_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_cmd_cnt  = perf_cmd_q;
    assign perf_err_cnt  = perf_err_q;
    assign perf_busy_cnt = perf_busy_q;
`endif

endmodule

// File: tb/tb_tinyalu_driver.sv
// Bench for tinyalu_driver: reactive ALU model, response scoreboard built from
// command-level rules, and per-cycle interface checks.
module tb_tinyalu_driver;

    localparam int T_CYC = 16;
    localparam int CNT_W = 16;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
`ifdef TINYALU_DRV_PERF_EN
    logic [CNT_W-1:0] perf_cmd_cnt, perf_err_cnt, perf_busy_cnt;
    int m_cmd, m_err, m_busy;
`endif

    tinyalu_driver #(.TIMEOUT_CYCLES(T_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
`ifdef TINYALU_DRV_PERF_EN
        .perf_cmd_cnt(perf_cmd_cnt),
        .perf_err_cnt(perf_err_cnt),
        .perf_busy_cnt(perf_busy_cnt),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .alu_start(alu_start),
        .alu_op(alu_op),
        .alu_A(alu_A),
        .alu_B(alu_B),
        .alu_done(alu_done),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_op(rsp_op),
        .rsp_err(rsp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] exp_q[$];      // {err, op, result} per accepted command
    int          exp_len_q[$];  // expected alu_start high length per ALU command
    int          alu_delay = 1;
    logic        stray_req = 1'b0;
    logic [19:0] last_rsp = '0;
    int          last_len = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return {8'h00, a} + {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model: done arrives `alu_delay` cycles after start rises (255 = never).
    initial begin
        int age;
        age = 0;
        alu_done = 1'b0;
        alu_result = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            if (alu_start) age++;
            else age = 0;
            if (alu_start && (age == alu_delay + 1)) begin
                alu_done = 1'b1;
                alu_result = alu_fn(alu_op, alu_A, alu_B);
            end else if (stray_req) begin
                stray_req = 1'b0;
                alu_done = 1'b1;
                alu_result = 16'hBEEF;
            end else begin
                alu_done = 1'b0;
                alu_result = 16'hDEAD;
            end
        end
    end

    // Per-cycle compare process.
    logic        prev_valid, prev_ready, prev_start;
    logic [19:0] prev_rsp;
    logic [18:0] prev_alu;
    int          start_len, gap;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_start = 1'b0;
            start_len  = 0;
            gap        = 100;
`ifdef TINYALU_DRV_PERF_EN
            m_cmd = 0; m_err = 0; m_busy = 0;
`endif
        end else begin
`ifdef TINYALU_DRV_PERF_EN
            chk("perf_cmd_cnt", 32'(perf_cmd_cnt), 32'(m_cmd));
            chk("perf_err_cnt", 32'(perf_err_cnt), 32'(m_err));
            chk("perf_busy_cnt", 32'(perf_busy_cnt), 32'(m_busy));
            if (alu_start && m_busy < (1 << CNT_W) - 1) m_busy++;
`endif
            if (prev_valid && !prev_ready) begin
                chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                chk("rsp_data_hold", 32'({rsp_err, rsp_op, rsp_result}), 32'(prev_rsp));
            end
            if (rsp_valid || alu_start) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (rsp_valid && rsp_ready) begin
                last_rsp = {rsp_err, rsp_op, rsp_result};
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(last_rsp), 32'hFFFFFFFF);
                end else begin
                    chk("rsp", 32'(last_rsp), 32'(exp_q.pop_front()));
                end
`ifdef TINYALU_DRV_PERF_EN
                if (m_cmd < (1 << CNT_W) - 1) m_cmd++;
                if (rsp_err && m_err < (1 << CNT_W) - 1) m_err++;
`endif
            end
            if (alu_start) begin
                if (!prev_start) begin
                    chk("start_gap_ge2", 32'(gap >= 2), 32'd1);
                    chk("start_expected", 32'(exp_len_q.size() != 0), 32'd1);
                    start_len = 0;
                end else begin
                    chk("alu_in_stable", 32'({alu_op, alu_A, alu_B}), 32'(prev_alu));
                end
                start_len++;
                gap = 0;
            end else begin
                if (prev_start) begin
                    last_len = start_len;
                    if (exp_len_q.size() != 0) chk("start_len", 32'(start_len), 32'(exp_len_q.pop_front()));
                end
                gap++;
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_rsp   = {rsp_err, rsp_op, rsp_result};
            prev_start = alu_start;
            prev_alu   = {alu_op, alu_A, alu_B};
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int dly);
        int n;
        logic [19:0] e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        alu_delay = dly;
        if (op == 3'd0) e = {1'b0, op, 16'h0000};
        else if (op >= 3'd5) e = {1'b1, op, 16'h0000};
        else if (dly + 1 <= T_CYC) e = {1'b0, op, alu_fn(op, a, b)};
        else e = {1'b1, op, 16'h0000};
        exp_q.push_back(e);
        if (op >= 3'd1 && op <= 3'd4) exp_len_q.push_back((dly + 1 <= T_CYC) ? dly + 1 : T_CYC);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_rsp", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_alu_A"}, 32'(alu_A), 32'd0);
        chk({tag, "_alu_B"}, 32'(alu_B), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_a = 8'h00;
        cmd_b = 8'h00;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        send(3'd1, 8'hFF, 8'h01, 1);
        drain();
        chk("add_ff_01", 32'(last_rsp), 32'({1'b0, 3'd1, 16'h0100}));
        chk("add_start_len", 32'(last_len), 32'd2);

        send(3'd4, 8'hFF, 8'hFF, 3);
        drain();
        chk("mul_ff_ff", 32'(last_rsp), 32'({1'b0, 3'd4, 16'hFE01}));

        send(3'd0, 8'h12, 8'h34, 1);
        send(3'd6, 8'h56, 8'h78, 1);
        drain();
        chk("illegal_110", 32'(last_rsp), 32'({1'b1, 3'd6, 16'h0000}));

        send(3'd3, 8'hA5, 8'h0F, 255);
        drain();
        chk("xor_timeout", 32'(last_rsp), 32'({1'b1, 3'd3, 16'h0000}));
        chk("xor_timeout_len", 32'(last_len), 32'd16);
        send(3'd1, 8'h12, 8'h34, 2);
        drain();
        chk("add_after_timeout", 32'(last_rsp), 32'({1'b0, 3'd1, 16'h0046}));

        // done on the terminal-count cycle wins over the timeout
        send(3'd2, 8'hF0, 8'h3C, T_CYC - 1);
        drain();
        chk("and_done_at_limit", 32'(last_rsp), 32'({1'b0, 3'd2, 16'h0030}));
        chk("and_done_len", 32'(last_len), 32'd16);
        send(3'd2, 8'hF0, 8'h3C, T_CYC);
        drain();
        chk("and_timeout", 32'(last_rsp), 32'({1'b1, 3'd2, 16'h0000}));

        // back-pressured response, stray done ignored, then back-to-back command
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(3'd1, 8'h80, 8'h80, 2);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        stray_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(3'd3, 8'h3C, 8'hFF, 1);
        drain();
        chk("xor_after_bp", 32'(last_rsp), 32'({1'b0, 3'd3, 16'h00C3}));

        // reset in the middle of an ALU command
        send(3'd4, 8'h10, 8'h10, 10);
        repeat (4) @(negedge clk);
        chk("mul_in_issue", 32'(alu_start), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        exp_q.delete();
        exp_len_q.delete();
        @(negedge clk);
`ifdef TINYALU_DRV_PERF_EN
        chk("perf_cmd_reset", 32'(perf_cmd_cnt), 32'd0);
        chk("perf_busy_reset", 32'(perf_busy_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(3'd1, 8'h01, 8'h02, 1);
        drain();
        chk("add_after_reset", 32'(last_rsp), 32'({1'b0, 3'd1, 16'h0003}));
`ifdef TINYALU_DRV_PERF_EN
        @(negedge clk);
        chk("perf_cmd_after_add", 32'(perf_cmd_cnt), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
